// File: rtl/reshape_pkg.sv
// Shared encodings for the reshape command path: one-hot op codes, scheduler states, default widths.
package reshape_pkg;

  localparam int CFG_W_DEF = 32;

  localparam logic [3:0] OP_CONCAT   = 4'b0001;
  localparam logic [3:0] OP_SPLIT    = 4'b0010;
  localparam logic [3:0] OP_MAXPOOL  = 4'b0100;
  localparam logic [3:0] OP_UPSAMPLE = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT2,
    ST_KICK,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic is_onehot4(input logic [3:0] op);
    return (op != 4'd0) && ((op & (op - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/reshape_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO with flush; accepts a push while full if a pop
// happens in the same cycle.
module reshape_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 132
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/reshape_cmd_scheduler.sv
// Runs queued reshape commands one at a time: load config, pulse op, kick DMA, wait for stream end
// and write-back, retire. Includes event capture, watchdog and abort flush.
module reshape_cmd_scheduler
  import reshape_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int CFG_W     = CFG_W_DEF,
  parameter int TMO_W     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [4*CFG_W-1:0] cmd_cfg,
  input  logic [TMO_W-1:0]   tmo_limit,
  input  logic               abort,
  output logic [3:0]         control_reshape,
  output logic [CFG_W-1:0]   reg_4,
  output logic [CFG_W-1:0]   reg_5,
  output logic [CFG_W-1:0]   reg_6,
  output logic [CFG_W-1:0]   reg_7,
  output logic               dma_rd_start,
  output logic               dma_rd2_start,
  output logic               dma_wr_start,
  input  logic               reshape_last,
  input  logic               wr_done,
  output logic               busy,
  output logic               cmd_done,
  output logic [15:0]        done_cnt,
  output logic               err_bad_op,
  output logic               err_tmo
);

  localparam int FW = 4 + 4*CFG_W;

  state_t             state_q, state_d;
  logic [FW-1:0]      fifo_dout;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [3:0]         op_q;
  logic [4*CFG_W-1:0] cfg_q;
  logic               wait_q;
  logic               seen_last, seen_wr;
  logic               last_any, wr_any, evt_both;
  logic [TMO_W-1:0]   wdog;
  logic               tmo_fire, tmo_q;

  assign pop       = (state_q == ST_IDLE) && !fifo_empty && !abort;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign cmd_ready = !fifo_full || pop;
  assign push      = cmd_valid && cmd_ready && !abort;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  assign last_any  = seen_last || reshape_last;
  assign wr_any    = seen_wr || wr_done;
  assign evt_both  = last_any && wr_any;
  assign tmo_fire  = (tmo_limit != '0) && (wdog == tmo_limit - 1'b1);

  reshape_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .din   ({cmd_op, cmd_cfg}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d         = state_q;
    control_reshape = 4'd0;
    dma_rd_start    = 1'b0;
    dma_rd2_start   = 1'b0;
    dma_wr_start    = 1'b0;
    cmd_done        = 1'b0;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD:  state_d = is_onehot4(op_q) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        control_reshape = op_q;
        state_d         = ST_WAIT2;
      end
      ST_WAIT2: if (wait_q) state_d = ST_KICK;
      ST_KICK: begin
        dma_rd_start  = 1'b1;
        dma_wr_start  = 1'b1;
        dma_rd2_start = (op_q == OP_CONCAT);
        state_d       = ST_RUN;
      end
      ST_RUN:   if (evt_both || tmo_fire) state_d = ST_DONE;
      ST_DONE: begin
        cmd_done = !tmo_q;
        state_d  = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d         = ST_IDLE;
      control_reshape = 4'd0;
      dma_rd_start    = 1'b0;
      dma_rd2_start   = 1'b0;
      dma_wr_start    = 1'b0;
      cmd_done        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 4'd0;
      cfg_q      <= '0;
      wait_q     <= 1'b0;
      seen_last  <= 1'b0;
      seen_wr    <= 1'b0;
      wdog       <= '0;
      tmo_q      <= 1'b0;
      reg_4      <= '0;
      reg_5      <= '0;
      reg_6      <= '0;
      reg_7      <= '0;
      done_cnt   <= 16'd0;
      err_bad_op <= 1'b0;
      err_tmo    <= 1'b0;
    end else if (abort) begin
      state_q   <= ST_IDLE;
      seen_last <= 1'b0;
      seen_wr   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        op_q  <= fifo_dout[FW-1 -: 4];
        cfg_q <= fifo_dout[4*CFG_W-1:0];
      end
      case (state_q)
        ST_LOAD: begin
          reg_4 <= cfg_q[0*CFG_W +: CFG_W];
          reg_5 <= cfg_q[1*CFG_W +: CFG_W];
          reg_6 <= cfg_q[2*CFG_W +: CFG_W];
          reg_7 <= cfg_q[3*CFG_W +: CFG_W];
          if (!is_onehot4(op_q)) err_bad_op <= 1'b1;
        end
        ST_ISSUE: wait_q <= 1'b0;
        ST_WAIT2: wait_q <= 1'b1;
        ST_KICK: begin
          seen_last <= 1'b0;
          seen_wr   <= 1'b0;
          wdog      <= '0;
          tmo_q     <= 1'b0;
        end
        ST_RUN: begin
          seen_last <= last_any;
          seen_wr   <= wr_any;
          wdog      <= wdog + 1'b1;
          // Completion in the same cycle as the watchdog wins.
          if (tmo_fire && !evt_both) begin
            err_tmo <= 1'b1;
            tmo_q   <= 1'b1;
          end
        end
        ST_DONE: if (!tmo_q) done_cnt <= done_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reshape_cmd_scheduler.sv
// Directed bench for reshape_cmd_scheduler; a negedge monitor checks pulses against queued expectations.
module tb_reshape_cmd_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_op = 4'd0;
  logic [127:0] cmd_cfg = '0;
  logic [19:0]  tmo_limit = '0;
  logic         abort = 1'b0;
  logic [3:0]   control_reshape;
  logic [31:0]  reg_4, reg_5, reg_6, reg_7;
  logic         dma_rd_start, dma_rd2_start, dma_wr_start;
  logic         reshape_last = 1'b0;
  logic         wr_done = 1'b0;
  logic         busy, cmd_done;
  logic [15:0]  done_cnt;
  logic         err_bad_op, err_tmo;

  reshape_cmd_scheduler dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_cfg(cmd_cfg), .tmo_limit(tmo_limit), .abort(abort), .control_reshape(control_reshape),
    .reg_4(reg_4), .reg_5(reg_5), .reg_6(reg_6), .reg_7(reg_7), .dma_rd_start(dma_rd_start),
    .dma_rd2_start(dma_rd2_start), .dma_wr_start(dma_wr_start), .reshape_last(reshape_last),
    .wr_done(wr_done), .busy(busy), .cmd_done(cmd_done), .done_cnt(done_cnt),
    .err_bad_op(err_bad_op), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [3:0]  exp_ctl[$];
  logic [31:0] exp_done[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [3:0]  last_ctl = 4'd0;
  int          ctl_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every pulse the DUT emits must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (control_reshape != 4'd0) begin
        if (exp_ctl.size() == 0) chk("unexpected control_reshape", control_reshape, 0);
        else chk("control_reshape op", control_reshape, exp_ctl.pop_front());
        last_ctl = control_reshape;
        ctl_cyc  = cyc;
      end
      if (dma_rd_start || dma_wr_start || dma_rd2_start) begin
        chk("kick rd", dma_rd_start, 1);
        chk("kick wr", dma_wr_start, 1);
        chk("kick rd2", dma_rd2_start, last_ctl == 4'b0001);
        chk("issue to kick latency", cyc - ctl_cyc, 3);
      end
      if (cmd_done) begin
        if (exp_done.size() == 0) chk("unexpected cmd_done", cmd_done, 0);
        else begin
          chk("retire reg_4", reg_4, exp_done.pop_front());
          chk("done_cnt at retire", done_cnt, exp_cnt);
          exp_cnt++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [3:0] op, input logic [127:0] cfg, input int max, output int stall);
    stall = 0;
    cmd_op = op; cmd_cfg = cfg; cmd_valid = 1'b1;
    while (!cmd_ready && stall < max) begin tick(1); stall++; end
    chk("push accepted", cmd_ready, 1);
    if (cmd_ready) tick(1);
    cmd_valid = 1'b0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return dma_rd_start;
      1: return cmd_done;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input int which, input int max, input string nm);
    int k = 0;
    while (!sig(which) && k < max) begin tick(1); k++; end
    chk(nm, sig(which), 1);
  endtask

  task automatic respond(input bit wait_kick, input int gap);
    if (wait_kick) wait_for(0, 60, "kick seen");
    tick(gap);
    reshape_last = 1'b1; wr_done = 1'b1;
    tick(1);
    reshape_last = 1'b0; wr_done = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout: cyc %0d expected under 30000", cyc);
    $fatal(1);
  end

  initial begin
    int st, st5;
    logic [3:0] op;
    #1;
    chk("rst control_reshape", control_reshape, 0);
    chk("rst busy", busy, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst done_cnt", done_cnt, 0);
    chk("rst reg_4", reg_4, 0);
    chk("rst errs", {err_bad_op, err_tmo}, 0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // 1: split, staggered events
    exp_ctl.push_back(4'b0010); exp_done.push_back(32'h11);
    push(4'b0010, {32'h44, 32'h33, 32'h22, 32'h11}, 5, st);
    chk("t1 busy after push", busy, 1);
    tick(1);
    chk("t1 no control in LOAD", control_reshape, 0);
    tick(1);
    chk("t1 pop to control 2 cycles", control_reshape, 4'b0010);
    chk("t1 reg_7", reg_7, 32'h44);
    chk("t1 reg_4", reg_4, 32'h11);
    wait_for(0, 10, "t1 kick");
    tick(2);
    reshape_last = 1'b1; tick(1); reshape_last = 1'b0;
    tick(9);
    chk("t1 no done before wr_done", cmd_done, 0);
    wr_done = 1'b1; tick(1); wr_done = 1'b0;
    chk("t1 cmd_done", cmd_done, 1);
    tick(1);
    chk("t1 done_cnt", done_cnt, 1);
    chk("t1 idle", busy, 0);

    // 2: concat, both events same cycle
    exp_ctl.push_back(4'b0001); exp_done.push_back(32'hA1);
    push(4'b0001, {96'h0, 32'hA1}, 5, st);
    wait_for(0, 10, "t2 kick");
    tick(3);
    reshape_last = 1'b1; wr_done = 1'b1;
    tick(1);
    reshape_last = 1'b0; wr_done = 1'b0;
    chk("t2 done next cycle", cmd_done, 1);
    tick(1);
    chk("t2 done_cnt", done_cnt, 2);

    // 3: fill FIFO behind a running command; fifth push stalls
    exp_ctl.push_back(4'b0100); exp_done.push_back(32'h100);
    push(4'b0100, {96'h0, 32'h100}, 5, st);
    wait_for(0, 10, "t3 kick A");
    for (int i = 1; i <= 4; i++) begin
      op = 4'b0001 << (i % 4);
      exp_ctl.push_back(op); exp_done.push_back(32'h100 + i);
      push(op, {96'h0, 32'h100 + i}, 3, st);
    end
    chk("t3 full ready low", cmd_ready, 0);
    exp_ctl.push_back(4'b0010); exp_done.push_back(32'h105);
    fork
      push(4'b0010, {96'h0, 32'h105}, 60, st5);
      respond(1'b0, 3);
    join
    chk("t3 fifth push stalled", st5 > 0, 1);
    repeat (5) respond(1'b1, 2);
    wait_for(2, 40, "t3 drained");
    chk("t3 done_cnt", done_cnt, 8);

    // 4: bad op, then a valid one
    push(4'b0011, {96'h0, 32'h55}, 5, st);
    tick(4);
    chk("t4 err_bad_op", err_bad_op, 1);
    chk("t4 done_cnt unchanged", done_cnt, 8);
    chk("t4 idle", busy, 0);
    exp_ctl.push_back(4'b1000); exp_done.push_back(32'h66);
    push(4'b1000, {96'h0, 32'h66}, 5, st);
    respond(1'b1, 2);
    wait_for(2, 20, "t4 idle after good cmd");
    chk("t4 done_cnt", done_cnt, 9);

    // 5: watchdog
    tmo_limit = 20'd100;
    exp_ctl.push_back(4'b0100);
    push(4'b0100, {96'h0, 32'h77}, 5, st);
    wait_for(0, 10, "t5 kick");
    tick(100);
    chk("t5 err_tmo not early", err_tmo, 0);
    tick(1);
    chk("t5 err_tmo at 100", err_tmo, 1);
    chk("t5 busy in DONE", busy, 1);
    tick(1);
    chk("t5 idle", busy, 0);
    chk("t5 done_cnt unchanged", done_cnt, 9);
    tmo_limit = '0;

    // 6a: abort during ISSUE suppresses the pulse
    push(4'b0010, {96'h0, 32'h88}, 5, st);
    tick(2);
    abort = 1'b1; #1;
    chk("t6 control suppressed by abort", control_reshape, 0);
    tick(1);
    abort = 1'b0;
    chk("t6a idle after abort", busy, 0);

    // 6b: abort with one running and two queued, plus a push in the abort cycle
    exp_ctl.push_back(4'b0010);
    push(4'b0010, {96'h0, 32'h99}, 5, st);
    wait_for(0, 10, "t6 kick");
    push(4'b0100, {96'h0, 32'h9A}, 3, st);
    push(4'b1000, {96'h0, 32'h9B}, 3, st);
    tick(2);
    abort = 1'b1; cmd_op = 4'b0010; cmd_valid = 1'b1;
    tick(1);
    abort = 1'b0; cmd_valid = 1'b0;
    chk("t6 busy clear after abort", busy, 0);
    chk("t6 cmd_ready after abort", cmd_ready, 1);
    tick(5);
    chk("t6 abort push discarded", busy, 0);
    chk("t6 done_cnt unchanged", done_cnt, 9);

    // 6c: asynchronous reset mid-RUN
    exp_ctl.push_back(4'b0100);
    push(4'b0100, {96'h0, 32'hAB}, 5, st);
    wait_for(0, 10, "t6c kick");
    tick(3);
    rst = 1'b1; #1;
    chk("t6c async reg_4", reg_4, 0);
    chk("t6c async done_cnt", done_cnt, 0);
    chk("t6c async busy", busy, 0);
    chk("t6c async errs", {err_bad_op, err_tmo}, 0);
    chk("t6c async cmd_ready", cmd_ready, 1);
    tick(2);
    rst = 1'b0;
    tick(2);

    chk("pending control expectations", exp_ctl.size(), 0);
    chk("pending retire expectations", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
